counter_bank: RTL and testbench

COUNTER_BANK -- requirements
Module: counter_bank

---
 rtl/counter_bank.sv | 98 +++++++++
 tb/tb_counter_bank.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_bank.sv
// Bank of independent up/down counters with wrap/saturate mode, terminal-count pulse and sticky
// overflow. Define COUNTER_BANK_PRESCALE_EN to gate steps with a free-running prescaler tick.
module counter_bank #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned PRESCALE = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS-1:0]       up,
  input  logic [CHANNELS-1:0]       clr,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS*WIDTH-1:0] load_val,
  input  logic                      sat,
  input  logic [CHANNELS-1:0]       ovf_clr,
  output logic [CHANNELS*WIDTH-1:0] count,
  output logic [CHANNELS-1:0]       tc,
  output logic [CHANNELS-1:0]       ovf
);

  logic                      tick;
  logic [CHANNELS*WIDTH-1:0] count_q, count_d;
  logic [CHANNELS-1:0]       tc_q, tc_d;
  logic [CHANNELS-1:0]       ovf_q, ovf_d;
  logic [CHANNELS-1:0]       step_en;
  logic [CHANNELS-1:0]       at_limit;
  logic [CHANNELS-1:0]       limit_evt;

`ifdef COUNTER_BANK_PRESCALE_EN
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PresLast = PW'(PRESCALE - 1);

  logic [PW-1:0] presc_q;

  assign tick = (presc_q == PresLast);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
    end else begin
      presc_q <= tick ? '0 : presc_q + PW'(1);
    end
  end
`else
  assign tick = 1'b1;

  logic unused_prescale;
  assign unused_prescale = ^PRESCALE;
`endif

  // A limit event is a step that would cross the top (up) or bottom (down) of the range.
  always_comb begin
    step_en  = '0;
    at_limit = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      step_en[i]  = en[i] & tick & ~clr[i] & ~load[i];
      at_limit[i] = up[i] ? (&count_q[i*WIDTH +: WIDTH]) : ~(|count_q[i*WIDTH +: WIDTH]);
    end
  end

  assign limit_evt = step_en & at_limit;

  always_comb begin
    count_d = count_q;
    tc_d    = limit_evt;
    // A coincident limit event wins over the clear request.
    ovf_d   = (ovf_q & ~ovf_clr) | limit_evt;
    for (int i = 0; i < CHANNELS; i++) begin
      if (clr[i]) begin
        count_d[i*WIDTH +: WIDTH] = '0;
      end else if (load[i]) begin
        count_d[i*WIDTH +: WIDTH] = load_val[i*WIDTH +: WIDTH];
      end else if (step_en[i] && !(at_limit[i] && sat)) begin
        // Modular arithmetic yields the wrap values at the limits.
        count_d[i*WIDTH +: WIDTH] = up[i] ? count_q[i*WIDTH +: WIDTH] + WIDTH'(1)
                                          : count_q[i*WIDTH +: WIDTH] - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      tc_q    <= '0;
      ovf_q   <= '0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_counter_bank.sv
// Self-checking bench for counter_bank: directed sequences, a vector table and randomized
// stimulus compared against an integer-arithmetic reference model.
module tb_counter_bank;

  localparam int WIDTH    = 8;
  localparam int CHANNELS = 4;
  localparam int PRESCALE = 4;
  localparam int MAXV     = (1 << WIDTH) - 1;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [CHANNELS-1:0]       en, up, clr, load, ovf_clr;
  logic [CHANNELS*WIDTH-1:0] load_val;
  logic                      sat;
  logic [CHANNELS*WIDTH-1:0] count;
  logic [CHANNELS-1:0]       tc, ovf;

  counter_bank #(
    .WIDTH   (WIDTH),
    .CHANNELS(CHANNELS),
    .PRESCALE(PRESCALE)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .up      (up),
    .clr     (clr),
    .load    (load),
    .load_val(load_val),
    .sat     (sat),
    .ovf_clr (ovf_clr),
    .count   (count),
    .tc      (tc),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int                  m_cnt[CHANNELS];
  logic [CHANNELS-1:0] m_tc, m_ovf;
  int                  m_cyc;

  typedef struct {
    logic [3:0]  en, up, clr, load, ovf_clr;
    logic        sat;
    logic [31:0] lv;
    logic [31:0] ec;
    logic [3:0]  et, eo;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] m_packed();
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < CHANNELS; i++) r[i*WIDTH +: WIDTH] = 8'(m_cnt[i]);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < CHANNELS; i++) m_cnt[i] = 0;
    m_tc  = '0;
    m_ovf = '0;
    m_cyc = 0;
  endtask

  task automatic model_edge();
    bit tick;
    int n;
`ifdef COUNTER_BANK_PRESCALE_EN
    tick = ((m_cyc % PRESCALE) == PRESCALE - 1);
`else
    tick = 1'b1;
`endif
    m_cyc++;
    for (int i = 0; i < CHANNELS; i++) begin
      m_tc[i] = 1'b0;
      if (ovf_clr[i]) m_ovf[i] = 1'b0;
      if (clr[i]) begin
        m_cnt[i] = 0;
      end else if (load[i]) begin
        m_cnt[i] = int'(load_val[i*WIDTH +: WIDTH]);
      end else if (en[i] && tick) begin
        n = up[i] ? m_cnt[i] + 1 : m_cnt[i] - 1;
        if (n < 0 || n > MAXV) begin
          m_tc[i]  = 1'b1;
          m_ovf[i] = 1'b1;
          if (!sat) m_cnt[i] = (n < 0) ? MAXV : 0;
        end else begin
          m_cnt[i] = n;
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] ec, input logic [3:0] et,
                       input logic [3:0] eo);
    checks++;
    if (count !== ec || tc !== et || ovf !== eo) begin
      errors++;
      $display("FAIL %s: count=%h tc=%b ovf=%b, expected count=%h tc=%b ovf=%b",
               name, count, tc, ovf, ec, et, eo);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rst) model_edge();
    else model_reset();
  endtask

  task automatic idle_inputs();
    en = '0; up = '0; clr = '0; load = '0; load_val = '0; sat = 1'b0; ovf_clr = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    #1;
    model_reset();
    check("reset_async", 32'h0, 4'h0, 4'h0);
    @(posedge clk);
    #1;
    check("reset_held", 32'h0, 4'h0, 4'h0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic add(input logic [3:0] e, input logic [3:0] u, input logic [3:0] c,
                     input logic [3:0] l, input logic [3:0] oc, input logic s,
                     input logic [31:0] lv, input logic [31:0] ec, input logic [3:0] et,
                     input logic [3:0] eo);
    vec_t v;
    v.en = e; v.up = u; v.clr = c; v.load = l; v.ovf_clr = oc; v.sat = s;
    v.lv = lv; v.ec = ec; v.et = et; v.eo = eo;
    tbl.push_back(v);
  endtask

  function automatic logic [7:0] pick_lv();
    case ($urandom_range(4))
      0: return 8'h00;
      1: return 8'h01;
      2: return 8'hFE;
      3: return 8'hFF;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    idle_inputs();
    #2;
    do_reset();

`ifndef COUNTER_BANK_PRESCALE_EN
    // Ten up-steps on channel 0 only
    en = 4'b0001; up = 4'b1111;
    for (int k = 0; k < 10; k++) begin
      step();
      check("ch0_count_up", m_packed(), m_tc, m_ovf);
    end
    check("ten_steps_ch0", 32'h0000000A, 4'h0, 4'h0);

    // Async reset mid-count, then a fresh step after release
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check("async_reset_midcount", 32'h0, 4'h0, 4'h0);
    @(negedge clk);
    rst = 1'b1;
    step();
    check("first_step_after_reset", 32'h00000001, 4'h0, 4'h0);

    do_reset();

    // Vector table, applied from reset; expectations hand-derived
    //   en      up      clr     load    ovfclr  sat   load_val      count         tc    ovf
    add(4'h0, 4'hF, 4'h0, 4'h4, 4'h0, 1'b0, 32'h00FE0000, 32'h00FE0000, 4'h0, 4'h0);
    add(4'h4, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 32'h0,        32'h00FF0000, 4'h0, 4'h0);
    add(4'h4, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 32'h0,        32'h00000000, 4'h4, 4'h4);
    add(4'h4, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 32'h0,        32'h00010000, 4'h0, 4'h4);
    add(4'h0, 4'hF, 4'h0, 4'h0, 4'h4, 1'b0, 32'h0,        32'h00010000, 4'h0, 4'h0);
    add(4'h2, 4'hD, 4'h0, 4'h0, 4'h0, 1'b1, 32'h0,        32'h00010000, 4'h2, 4'h2);
    add(4'h2, 4'hD, 4'h0, 4'h0, 4'h0, 1'b1, 32'h0,        32'h00010000, 4'h2, 4'h2);
    add(4'h2, 4'hD, 4'h0, 4'h0, 4'h0, 1'b1, 32'h0,        32'h00010000, 4'h2, 4'h2);
    add(4'h0, 4'hD, 4'h0, 4'h0, 4'h0, 1'b1, 32'h0,        32'h00010000, 4'h0, 4'h2);
    add(4'h8, 4'hF, 4'h8, 4'h8, 4'h0, 1'b0, 32'h55000000, 32'h00010000, 4'h0, 4'h2);
    add(4'h8, 4'hF, 4'h0, 4'h8, 4'h0, 1'b0, 32'h55000000, 32'h55010000, 4'h0, 4'h2);
    add(4'h8, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 32'h0,        32'h56010000, 4'h0, 4'h2);
    add(4'h0, 4'hF, 4'h8, 4'h0, 4'h0, 1'b0, 32'h0,        32'h00010000, 4'h0, 4'h2);
    add(4'h0, 4'hF, 4'h0, 4'h1, 4'h0, 1'b0, 32'h000000FF, 32'h000100FF, 4'h0, 4'h2);
    add(4'h1, 4'hF, 4'h0, 4'h0, 4'h1, 1'b0, 32'h0,        32'h00010000, 4'h1, 4'h3);
    add(4'h0, 4'hF, 4'h0, 4'h0, 4'h3, 1'b0, 32'h0,        32'h00010000, 4'h0, 4'h0);
    add(4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 32'h0,        32'h00000000, 4'h0, 4'h0);
    add(4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 32'h0,        32'h00000000, 4'h4, 4'h4);
    add(4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 32'h0,        32'h00FF0000, 4'h4, 4'h4);
    foreach (tbl[k]) begin
      en = tbl[k].en; up = tbl[k].up; clr = tbl[k].clr; load = tbl[k].load;
      ovf_clr = tbl[k].ovf_clr; sat = tbl[k].sat; load_val = tbl[k].lv;
      step();
      check($sformatf("table_row%0d", k), tbl[k].ec, tbl[k].et, tbl[k].eo);
    end
`else
    // Prescaled stepping: one step per PRESCALE cycles
    en = 4'b0001; up = 4'b1111;
    for (int k = 0; k < 16; k++) begin
      step();
      check("prescaled_step", m_packed(), m_tc, m_ovf);
      if (k == 2) check("no_step_before_first_tick", 32'h0, 4'h0, 4'h0);
    end
    check("sixteen_cycles_four_steps", 32'h00000004, 4'h0, 4'h0);
`endif

    // Randomized stimulus against the reference model
    do_reset();
    for (int k = 0; k < 600; k++) begin
      en = 4'($urandom);
      up = ($urandom_range(3) == 0) ? 4'($urandom) : up;
      for (int i = 0; i < CHANNELS; i++) begin
        clr[i]     = ($urandom_range(15) == 0);
        load[i]    = ($urandom_range(11) == 0);
        ovf_clr[i] = ($urandom_range(7) == 0);
        load_val[i*WIDTH +: WIDTH] = pick_lv();
      end
      if ($urandom_range(19) == 0) sat = ~sat;
      if ($urandom_range(149) == 0) begin
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check("random_async_reset", 32'h0, 4'h0, 4'h0);
        @(negedge clk);
        rst = 1'b1;
      end
      step();
      check("random", m_packed(), m_tc, m_ovf);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
